// File: rtl/ace_ccu_pkg.sv
// Shared ACE CCU definitions: snoop response (CRRESP) layout and bit positions.
package ace_ccu_pkg;

    localparam int unsigned CR_DATA_TRANSFER = 0;
    localparam int unsigned CR_ERROR         = 1;
    localparam int unsigned CR_PASS_DIRTY    = 2;
    localparam int unsigned CR_IS_SHARED     = 3;
    localparam int unsigned CR_WAS_UNIQUE    = 4;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;

endpackage

// File: rtl/ace_ccu_snoop_resp_collector.sv
// Collects CR responses from the snooped ports of one request and presents
// the ORed response, DataTransfer port mask and request context downstream.
module ace_ccu_snoop_resp_collector
    import ace_ccu_pkg::*;
#(
    parameter int unsigned NoPorts = 4,
    parameter type         ctx_t   = logic
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [NoPorts-1:0]      req_mask_i,
    input  ctx_t                    req_ctx_i,
    input  logic [NoPorts-1:0]      cr_valid_i,
    output logic [NoPorts-1:0]      cr_ready_o,
    input  logic [NoPorts-1:0][4:0] cr_resp_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [4:0]              resp_o,
    output logic [NoPorts-1:0]      dt_mask_o,
    output ctx_t                    ctx_o
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OUTPUT
    } state_e;

    state_e             state_q, state_d;
    logic [NoPorts-1:0] pending_q, pending_d;
    crresp_t            acc_q, acc_d;
    logic [NoPorts-1:0] dt_q, dt_d;
    ctx_t               ctx_q, ctx_d;

    always_comb begin
        crresp_t r;
        r           = '0;
        state_d     = state_q;
        pending_d   = pending_q;
        acc_d       = acc_q;
        dt_d        = dt_q;
        ctx_d       = ctx_q;
        req_ready_o = 1'b0;
        valid_o     = 1'b0;
        cr_ready_o  = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    pending_d = req_mask_i;
                    ctx_d     = req_ctx_i;
                    acc_d     = '0;
                    dt_d      = '0;
                    state_d   = (|req_mask_i) ? COLLECT : OUTPUT;
                end
            end
            COLLECT: begin
                // ready comes from registered pending only, never from cr_valid_i
                cr_ready_o = pending_q;
                for (int unsigned i = 0; i < NoPorts; i++) begin
                    if (pending_q[i] && cr_valid_i[i]) begin
                        r            = crresp_t'(cr_resp_i[i]);
                        pending_d[i] = 1'b0;
                        acc_d        = acc_d | r;
                        dt_d[i]      = r.data_transfer;
                    end
                end
                if (pending_d == '0) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            acc_q     <= '0;
            dt_q      <= '0;
            ctx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            acc_q     <= acc_d;
            dt_q      <= dt_d;
            ctx_q     <= ctx_d;
        end
    end

    assign resp_o    = acc_q;
    assign dt_mask_o = dt_q;
    assign ctx_o     = ctx_q;

endmodule

// File: tb/tb_ace_ccu_snoop_resp_collector.sv
// Directed bench for the snoop response collector, four ports, 8-bit context.
module tb_ace_ccu_snoop_resp_collector;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [3:0]       req_mask_i;
    logic [7:0]       req_ctx_i;
    logic [3:0]       cr_valid_i;
    logic [3:0]       cr_ready_o;
    logic [3:0][4:0]  cr_resp_i;
    logic             valid_o;
    logic             ready_i;
    logic [4:0]       resp_o;
    logic [3:0]       dt_mask_o;
    logic [7:0]       ctx_o;

    int unsigned total = 0;
    int unsigned fails = 0;

    always #5 clk_i = ~clk_i;

    ace_ccu_snoop_resp_collector #(
        .NoPorts (4),
        .ctx_t   (logic [7:0])
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_mask_i  (req_mask_i),
        .req_ctx_i   (req_ctx_i),
        .cr_valid_i  (cr_valid_i),
        .cr_ready_o  (cr_ready_o),
        .cr_resp_i   (cr_resp_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .resp_o      (resp_o),
        .dt_mask_o   (dt_mask_o),
        .ctx_o       (ctx_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic request(input logic [3:0] mask, input logic [7:0] ctx);
        req_valid_i = 1'b1;
        req_mask_i  = mask;
        req_ctx_i   = ctx;
        tick();
        req_valid_i = 1'b0;
        req_mask_i  = '0;
    endtask

    task automatic release_output();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_mask_i  = '0;
        req_ctx_i   = '0;
        cr_valid_i  = '0;
        cr_resp_i   = '0;
        ready_i     = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_cr_ready", 32'(cr_ready_o), 32'h0);
        check("rst_resp", 32'(resp_o), 32'h0);
        check("rst_dt_mask", 32'(dt_mask_o), 32'h0);
        check("rst_ctx", 32'(ctx_o), 32'h0);

        // Two ports answering in separate cycles
        request(4'b1010, 8'hA5);
        check("t1_cr_ready_c2", 32'(cr_ready_o), 32'hA);
        check("t1_req_ready_c2", 32'(req_ready_o), 32'd0);
        cr_valid_i   = 4'b0010;
        cr_resp_i[1] = 5'b01000;
        tick();
        cr_valid_i = '0;
        check("t1_cr_ready_c3", 32'(cr_ready_o), 32'h8);
        check("t1_valid_c3", 32'(valid_o), 32'd0);
        tick();
        cr_valid_i   = 4'b1000;
        cr_resp_i[3] = 5'b00001;
        check("t1_valid_c4", 32'(valid_o), 32'd0);
        tick();
        cr_valid_i = '0;
        check("t1_valid_c5", 32'(valid_o), 32'd1);
        check("t1_resp", 32'(resp_o), 32'h09);
        check("t1_dt_mask", 32'(dt_mask_o), 32'h8);
        check("t1_ctx", 32'(ctx_o), 32'hA5);
        check("t1_req_ready_out", 32'(req_ready_o), 32'd0);
        release_output();
        check("t1_idle_req_ready", 32'(req_ready_o), 32'd1);
        check("t1_idle_valid", 32'(valid_o), 32'd0);

        // All four ports in one cycle, Error bit on port 1, then back-pressure
        request(4'b1111, 8'h3C);
        cr_valid_i   = 4'b1111;
        cr_resp_i[0] = 5'b00001;
        cr_resp_i[1] = 5'b00010;
        cr_resp_i[2] = 5'b00100;
        cr_resp_i[3] = 5'b10000;
        check("t2_cr_ready", 32'(cr_ready_o), 32'hF);
        tick();
        cr_valid_i = '0;
        check("t2_valid", 32'(valid_o), 32'd1);
        check("t2_resp", 32'(resp_o), 32'h17);
        check("t2_dt_mask", 32'(dt_mask_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 32'(valid_o), 32'd1);
            check("t2_hold_resp", 32'(resp_o), 32'h17);
            check("t2_hold_ctx", 32'(ctx_o), 32'h3C);
            check("t2_hold_req_ready", 32'(req_ready_o), 32'd0);
        end
        release_output();

        // Empty mask goes straight to OUTPUT with cleared accumulators
        request(4'b0000, 8'h5A);
        check("t3_valid", 32'(valid_o), 32'd1);
        check("t3_resp", 32'(resp_o), 32'h0);
        check("t3_dt_mask", 32'(dt_mask_o), 32'h0);
        check("t3_ctx", 32'(ctx_o), 32'h5A);
        release_output();

        // Unmasked port 0 offers a response that must be ignored
        request(4'b0010, 8'h11);
        cr_valid_i   = 4'b0011;
        cr_resp_i[0] = 5'b11111;
        cr_resp_i[1] = 5'b01000;
        check("t4_cr_ready", 32'(cr_ready_o), 32'h2);
        tick();
        cr_valid_i = '0;
        check("t4_valid", 32'(valid_o), 32'd1);
        check("t4_resp", 32'(resp_o), 32'h08);
        check("t4_dt_mask", 32'(dt_mask_o), 32'h0);
        release_output();

        // Reset mid-collect, then a fresh single-port request
        request(4'b0110, 8'h77);
        cr_valid_i   = 4'b0010;
        cr_resp_i[1] = 5'b00100;
        tick();
        cr_valid_i = '0;
        check("t5_cr_ready_pend", 32'(cr_ready_o), 32'h4);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t5_rst_req_ready", 32'(req_ready_o), 32'd1);
        check("t5_rst_valid", 32'(valid_o), 32'd0);
        check("t5_rst_cr_ready", 32'(cr_ready_o), 32'h0);
        check("t5_rst_resp", 32'(resp_o), 32'h0);
        check("t5_rst_ctx", 32'(ctx_o), 32'h0);
        request(4'b0001, 8'h22);
        cr_valid_i   = 4'b0001;
        cr_resp_i[0] = 5'b00011;
        check("t5_cr_ready", 32'(cr_ready_o), 32'h1);
        tick();
        cr_valid_i = '0;
        check("t5_valid", 32'(valid_o), 32'd1);
        check("t5_resp", 32'(resp_o), 32'h03);
        check("t5_dt_mask", 32'(dt_mask_o), 32'h1);
        check("t5_ctx", 32'(ctx_o), 32'h22);
        release_output();
        check("t5_idle_req_ready", 32'(req_ready_o), 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
